// File: rtl/core_pkg.sv
// Shared types and constants for the decode->execute operand fetch slice.
//   XLEN      : operand/data width
//   CTRL_W    : width of the opaque decoded-control bundle
//   REG_IDX_W : register index width
//   idex_t    : contents of the ID/EX pipeline register
package core_pkg;

   localparam int XLEN      = 32;
   localparam int CTRL_W    = 16;
   localparam int REG_IDX_W = 5;

   typedef logic [CTRL_W-1:0] ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0]      pc;
      logic [XLEN-1:0]      imm;
      ctrl_t                ctrl;
      logic [REG_IDX_W-1:0] rd;
      logic                 rd_we;
      logic [XLEN-1:0]      op1;
      logic [XLEN-1:0]      op2;
   } idex_t;

   // True when a producer index names the same real register as a consumer.
   // x0 never matches because it has no producer.
   function automatic logic idx_match(input logic [REG_IDX_W-1:0] prod,
                                      input logic [REG_IDX_W-1:0] cons);
      return (prod != '0) && (prod == cons);
   endfunction

endpackage

// File: rtl/operand_bypass.sv
// Single-operand resolver: 4-way priority mux x0 / EX / WB / regfile.
// Ports:
//   idx             source register index
//   ex_we/ex_rd/ex_data   EX-stage forwarding source
//   wb_we/wb_wa/wb_wd     writeback forwarding source (regfile write is
//                         registered, so the same-cycle read is stale)
//   rf_data         regfile read data for idx
//   op              resolved operand
module operand_bypass
   import core_pkg::*;
(
   input  logic [REG_IDX_W-1:0] idx,
   input  logic                 ex_we,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic [XLEN-1:0]      ex_data,
   input  logic                 wb_we,
   input  logic [REG_IDX_W-1:0] wb_wa,
   input  logic [XLEN-1:0]      wb_wd,
   input  logic [XLEN-1:0]      rf_data,
   output logic [XLEN-1:0]      op
);

   always_comb begin
      op = rf_data;
      if (idx == '0)
         op = '0;
      else if (ex_we && (ex_rd == idx))
         op = ex_data;
      else if (wb_we && (wb_wa == idx))
         op = wb_wd;
   end

endmodule

// File: rtl/operand_fetch.sv
// Decode->execute stage: drives regfile read addresses, resolves both
// operands with EX/WB bypass, stalls on load-use hazards, and holds the
// ID/EX pipeline register behind a valid/ready handshake. flush drops both
// the incoming instruction and the one held in ID/EX.
// Ports:
//   clk, reset            core clock, async active-high reset
//   flush                 branch redirect kill
//   in_*                  decoded instruction from decode (valid/ready)
//   rf_ra*/rf_rd*         regfile read port pair
//   ex_fwd_*              EX-stage forwarding and pending (load) flag
//   wb_*                  regfile write port, also used for bypass
//   out_*                 ID/EX register contents toward execute (valid/ready)
module operand_fetch
   import core_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [REG_IDX_W-1:0] in_rs1,
   input  logic [REG_IDX_W-1:0] in_rs2,
   input  logic                 in_rs1_used,
   input  logic                 in_rs2_used,
   input  logic [REG_IDX_W-1:0] in_rd,
   input  logic                 in_rd_we,
   input  logic [XLEN-1:0]      in_imm,
   input  logic [CTRL_W-1:0]    in_ctrl,
   output logic [REG_IDX_W-1:0] rf_ra1,
   output logic [REG_IDX_W-1:0] rf_ra2,
   input  logic [XLEN-1:0]      rf_rd1,
   input  logic [XLEN-1:0]      rf_rd2,
   input  logic                 ex_fwd_we,
   input  logic [REG_IDX_W-1:0] ex_fwd_rd,
   input  logic [XLEN-1:0]      ex_fwd_data,
   input  logic                 ex_fwd_pend,
   input  logic                 wb_we,
   input  logic [REG_IDX_W-1:0] wb_wa,
   input  logic [XLEN-1:0]      wb_wd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_pc,
   output logic [XLEN-1:0]      out_imm,
   output logic [CTRL_W-1:0]    out_ctrl,
   output logic [REG_IDX_W-1:0] out_rd,
   output logic                 out_rd_we,
   output logic [XLEN-1:0]      out_op1,
   output logic [XLEN-1:0]      out_op2
);

   logic            valid_q;
   idex_t           idex_q;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            haz;
   logic            accept;

   assign rf_ra1 = in_rs1;
   assign rf_ra2 = in_rs2;

   operand_bypass u_byp1 (
      .idx     (in_rs1),
      .ex_we   (ex_fwd_we),
      .ex_rd   (ex_fwd_rd),
      .ex_data (ex_fwd_data),
      .wb_we   (wb_we),
      .wb_wa   (wb_wa),
      .wb_wd   (wb_wd),
      .rf_data (rf_rd1),
      .op      (op1)
   );

   operand_bypass u_byp2 (
      .idx     (in_rs2),
      .ex_we   (ex_fwd_we),
      .ex_rd   (ex_fwd_rd),
      .ex_data (ex_fwd_data),
      .wb_we   (wb_we),
      .wb_wa   (wb_wa),
      .wb_wd   (wb_wd),
      .rf_data (rf_rd2),
      .op      (op2)
   );

   // Load in EX whose result is not ready yet and is needed by this instruction.
   assign haz = in_valid && ex_fwd_we && ex_fwd_pend &&
                ((in_rs1_used && idx_match(ex_fwd_rd, in_rs1)) ||
                 (in_rs2_used && idx_match(ex_fwd_rd, in_rs2)));

   assign in_ready = (!valid_q || out_ready) && !haz;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         idex_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q      <= 1'b1;
         idex_q.pc    <= in_pc;
         idex_q.imm   <= in_imm;
         idex_q.ctrl  <= in_ctrl;
         idex_q.rd    <= in_rd;
         idex_q.rd_we <= in_rd_we;
         idex_q.op1   <= op1;
         idex_q.op2   <= op2;
      end else if (out_ready) begin
         // Consumed with nothing to replace it (includes a stall while draining).
         valid_q <= 1'b0;
      end
   end

   assign out_valid = valid_q;
   assign out_pc    = idex_q.pc;
   assign out_imm   = idex_q.imm;
   assign out_ctrl  = idex_q.ctrl;
   assign out_rd    = idex_q.rd;
   assign out_rd_we = idex_q.rd_we;
   assign out_op1   = idex_q.op1;
   assign out_op2   = idex_q.op2;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rs1, in_rs2;
   logic        in_rs1_used, in_rs2_used;
   logic [4:0]  in_rd;
   logic        in_rd_we;
   logic [31:0] in_imm;
   logic [15:0] in_ctrl;
   logic [4:0]  rf_ra1, rf_ra2;
   logic [31:0] rf_rd1, rf_rd2;
   logic        ex_fwd_we;
   logic [4:0]  ex_fwd_rd;
   logic [31:0] ex_fwd_data;
   logic        ex_fwd_pend;
   logic        wb_we;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc, out_imm;
   logic [15:0] out_ctrl;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [31:0] out_op1, out_op2;

   operand_fetch dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
      .in_rd(in_rd), .in_rd_we(in_rd_we), .in_imm(in_imm), .in_ctrl(in_ctrl),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .ex_fwd_we(ex_fwd_we), .ex_fwd_rd(ex_fwd_rd),
      .ex_fwd_data(ex_fwd_data), .ex_fwd_pend(ex_fwd_pend),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm), .out_ctrl(out_ctrl),
      .out_rd(out_rd), .out_rd_we(out_rd_we),
      .out_op1(out_op1), .out_op2(out_op2)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Bench-side architectural regfile and expected ID/EX contents.
   logic [31:0] rf [32];
   logic        m_valid;
   logic [31:0] m_pc, m_imm, m_op1, m_op2;
   logic [15:0] m_ctrl;
   logic [4:0]  m_rd;
   logic        m_rd_we;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] resolve(input logic [4:0] idx);
      if (idx == 0)                        return 32'h0;
      if (ex_fwd_we && ex_fwd_rd == idx)   return ex_fwd_data;
      if (wb_we && wb_wa == idx)           return wb_wd;
      return rf[idx];
   endfunction

   function automatic logic model_haz();
      logic dep;
      dep = (in_rs1_used && in_rs1 == ex_fwd_rd) || (in_rs2_used && in_rs2 == ex_fwd_rd);
      return in_valid && ex_fwd_we && ex_fwd_pend && (ex_fwd_rd != 0) && dep;
   endfunction

   function automatic logic model_ready();
      return (!m_valid || out_ready) && !model_haz();
   endfunction

   task automatic model_reset();
      m_valid = 0; m_pc = 0; m_imm = 0; m_ctrl = 0; m_rd = 0; m_rd_we = 0;
      m_op1 = 0; m_op2 = 0;
   endtask

   task automatic model_clock();
      if (flush) m_valid = 0;
      else if (in_valid && model_ready()) begin
         m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_ctrl = in_ctrl;
         m_rd = in_rd; m_rd_we = in_rd_we;
         m_op1 = resolve(in_rs1); m_op2 = resolve(in_rs2);
      end else if (out_ready) m_valid = 0;
      if (wb_we && wb_wa != 0) rf[wb_wa] = wb_wd;
   endtask

   task automatic check_regs();
      chk("out_valid", out_valid, m_valid);
      chk("out_pc",    out_pc,    m_pc);
      chk("out_imm",   out_imm,   m_imm);
      chk("out_ctrl",  out_ctrl,  m_ctrl);
      chk("out_rd",    out_rd,    m_rd);
      chk("out_rd_we", out_rd_we, m_rd_we);
      chk("out_op1",   out_op1,   m_op1);
      chk("out_op2",   out_op2,   m_op2);
   endtask

   // One clock: inputs are already set after a negedge; finish at next negedge.
   task automatic step();
      rf_rd1 = (in_rs1 == 0) ? 32'h0 : rf[in_rs1];
      rf_rd2 = (in_rs2 == 0) ? 32'h0 : rf[in_rs2];
      #1;
      chk("in_ready", in_ready, model_ready());
      chk("rf_ra1", rf_ra1, in_rs1);
      chk("rf_ra2", rf_ra2, in_rs2);
      @(posedge clk);
      model_clock();
      @(negedge clk);
      check_regs();
   endtask

   task automatic idle_inputs();
      flush = 0; in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0;
      in_rs1_used = 0; in_rs2_used = 0; in_rd = 0; in_rd_we = 0;
      in_imm = 0; in_ctrl = 0; ex_fwd_we = 0; ex_fwd_rd = 0;
      ex_fwd_data = 0; ex_fwd_pend = 0; wb_we = 0; wb_wa = 0; wb_wd = 0;
      out_ready = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held_pc;
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
      idle_inputs();
      rf_rd1 = 0; rf_rd2 = 0;
      reset = 1;
      model_reset();
      @(negedge clk); @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_pc",    out_pc,    0);
      chk("rst_op1",   out_op1,   0);
      chk("rst_ctrl",  out_ctrl,  0);
      reset = 0;

      // 1: plain regfile read
      rf[5] = 32'h11;
      in_valid = 1; in_pc = 32'h100; in_rs1 = 5; in_rs1_used = 1; in_rs2 = 0;
      in_rs2_used = 1; in_rd = 3; in_rd_we = 1; in_imm = 32'h4; in_ctrl = 16'h1234;
      step();
      chk("t1_valid", out_valid, 1);
      chk("t1_op1", out_op1, 32'h11);
      chk("t1_op2", out_op2, 32'h0);

      // 2: EX beats WB, then WB alone
      in_pc = 32'h200;
      ex_fwd_we = 1; ex_fwd_rd = 5; ex_fwd_data = 32'hAA;
      wb_we = 1; wb_wa = 5; wb_wd = 32'hBB;
      step();
      chk("t2_ex_op1", out_op1, 32'hAA);
      in_pc = 32'h210; ex_fwd_we = 0;
      step();
      chk("t2_wb_op1", out_op1, 32'hBB);

      // 3: load-use stall then release
      wb_we = 0;
      in_pc = 32'h300; in_rs1 = 0; in_rs2 = 7; in_rs2_used = 1;
      ex_fwd_we = 1; ex_fwd_rd = 7; ex_fwd_data = 32'h77; ex_fwd_pend = 1;
      step();
      chk("t3_stall_ready", in_ready, 0);
      chk("t3_bubble", out_valid, 0);
      ex_fwd_pend = 0;
      step();
      chk("t3_valid", out_valid, 1);
      chk("t3_op2", out_op2, 32'h77);
      chk("t3_pc", out_pc, 32'h300);

      // 4: backpressure holds outputs
      ex_fwd_we = 0;
      in_pc = 32'h400; out_ready = 0;
      held_pc = out_pc;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_hold_ready", in_ready, 0);
         chk("t4_hold_pc", out_pc, 32'h300);
         chk("t4_hold_valid", out_valid, 1);
      end
      out_ready = 1;
      step();
      chk("t4_next_pc", out_pc, 32'h400);

      // 5: flush drops both
      out_ready = 0; flush = 1; in_pc = 32'h500;
      step();
      chk("t5_valid", out_valid, 0);
      chk("t5_pc", out_pc, 32'h400);
      flush = 0; out_ready = 1;

      // 6: pending EX on x0 must not stall, operand reads zero
      in_pc = 32'h600; in_rs1 = 0; in_rs1_used = 1; in_rs2_used = 0;
      ex_fwd_we = 1; ex_fwd_rd = 0; ex_fwd_data = 32'hFF; ex_fwd_pend = 1;
      step();
      chk("t6_valid", out_valid, 1);
      chk("t6_op1", out_op1, 32'h0);
      chk("t6_ready", in_ready, 1);

      // Randomized traffic with occasional async reset
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            #1 reset = 1;
            #1;
            chk("async_rst_valid", out_valid, 0);
            chk("async_rst_pc", out_pc, 0);
            reset = 0;
            model_reset();
         end
         flush       = ($urandom_range(0, 15) == 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         in_pc       = $urandom;
         in_rs1      = 5'($urandom_range(0, 7));
         in_rs2      = 5'($urandom_range(0, 7));
         in_rs1_used = $urandom_range(0, 1);
         in_rs2_used = $urandom_range(0, 1);
         in_rd       = 5'($urandom);
         in_rd_we    = $urandom_range(0, 1);
         in_imm      = $urandom;
         in_ctrl     = 16'($urandom);
         ex_fwd_we   = $urandom_range(0, 1);
         ex_fwd_rd   = 5'($urandom_range(0, 7));
         ex_fwd_data = $urandom;
         ex_fwd_pend = ($urandom_range(0, 2) == 0);
         wb_we       = $urandom_range(0, 1);
         wb_wa       = 5'($urandom_range(0, 7));
         wb_wd       = $urandom;
         out_ready   = ($urandom_range(0, 9) < 7);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
